// File: rtl/ula_pkg.sv
// ula_pkg -- shared definitions for the ULA sequencer slice.
//   - ALU operation codes presented on ula_op (ULA_NOP = 4'b1111 makes the ALU
//     hold its registered output).
//   - MIPS opcode and funct field constants used by the decoder.
//   - Sequencer state enumeration.
package ula_pkg;

  // ALU operation codes
  localparam logic [3:0] ULA_AND = 4'b0000;
  localparam logic [3:0] ULA_OR  = 4'b0001;
  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_SUB = 4'b0110;
  localparam logic [3:0] ULA_SLT = 4'b0111;
  localparam logic [3:0] ULA_NOP = 4'b1111;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ula_decode.sv
// ula_decode -- combinational instruction decoder.
// Configuration: ULA_SEQ_IMM_EN enables the addi/slti/andi/ori I-types.
// Ports:
//   instr    in  32  MIPS instruction word
//   ula_op   out  4  ALU operation (ULA_NOP when not legal)
//   legal    out  1  instruction is decodable
//   use_imm  out  1  operand b comes from the immediate field
//   sign_ext out  1  immediate is sign-extended (else zero-extended)
module ula_decode
  import ula_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  ula_op,
  output logic        legal,
  output logic        use_imm,
  output logic        sign_ext
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // Register/immediate fields are consumed by the sequencer, not here.
  logic unused_fields;
  assign unused_fields = ^instr[25:6];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    ula_op   = ULA_NOP;
    legal    = 1'b0;
    use_imm  = 1'b0;
    sign_ext = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD: begin ula_op = ULA_ADD; legal = 1'b1; end
          FN_SUB: begin ula_op = ULA_SUB; legal = 1'b1; end
          FN_AND: begin ula_op = ULA_AND; legal = 1'b1; end
          FN_OR:  begin ula_op = ULA_OR;  legal = 1'b1; end
          FN_SLT: begin ula_op = ULA_SLT; legal = 1'b1; end
          default: ;
        endcase
      end
`ifdef ULA_SEQ_IMM_EN
      OPC_ADDI: begin ula_op = ULA_ADD; legal = 1'b1; use_imm = 1'b1; sign_ext = 1'b1; end
      OPC_SLTI: begin ula_op = ULA_SLT; legal = 1'b1; use_imm = 1'b1; sign_ext = 1'b1; end
      OPC_ANDI: begin ula_op = ULA_AND; legal = 1'b1; use_imm = 1'b1; end
      OPC_ORI:  begin ula_op = ULA_OR;  legal = 1'b1; use_imm = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/ula_sequencer.sv
// ula_sequencer -- issues one decoded instruction to an external registered
// ALU and returns the captured result through a valid/ready handshake.
// Sequence: IDLE -accept-> ISSUE (1 cycle) -> WAIT (1 cycle) -> DONE -> IDLE.
// Illegal instructions skip the ALU and go straight to DONE with res_illegal.
// Configuration: ULA_SEQ_IMM_EN adds immediate operands (addi/slti/andi/ori).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   instr_valid/ready   instruction handshake; instr, rs_data, rt_data operands
//   ula_op, ula_a/b     operation and operands to the ALU
//   ula_result          ALU registered result
//   res_valid/ready     result handshake; res_data, res_illegal result payload
module ula_sequencer
  import ula_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [3:0]  ula_op,
  output logic [31:0] ula_a,
  output logic [31:0] ula_b,
  input  logic [31:0] ula_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_illegal
);

  state_t      state;
  logic [3:0]  dec_op;
  logic        dec_legal;
  logic        dec_use_imm;
  logic        dec_sign_ext;
  logic [31:0] operand_b;

  ula_decode u_decode (
    .instr    (instr),
    .ula_op   (dec_op),
    .legal    (dec_legal),
    .use_imm  (dec_use_imm),
    .sign_ext (dec_sign_ext)
  );

`ifdef ULA_SEQ_IMM_EN
  always_comb begin
    operand_b = rt_data;
    if (dec_use_imm) begin
      operand_b = dec_sign_ext ? {{16{instr[15]}}, instr[15:0]}
                               : {16'h0000, instr[15:0]};
    end
  end
`else
  // Register-only build: the immediate flags are constant zero.
  logic unused_imm_flags;
  assign unused_imm_flags = dec_use_imm ^ dec_sign_ext;
  assign operand_b = rt_data;
`endif

  // rst gating keeps the handshake closed while reset is held.
  assign instr_ready = (state == ST_IDLE) && !rst;
  assign res_valid   = (state == ST_DONE);

  // ula_op is registered: the decoded op is loaded on the accept edge and
  // returned to NOP on the edge that ends ISSUE, so the ALU sees it for
  // exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ula_op      <= ULA_NOP;
      ula_a       <= '0;
      ula_b       <= '0;
      res_data    <= '0;
      res_illegal <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            if (dec_legal) begin
              ula_op <= dec_op;
              ula_a  <= rs_data;
              ula_b  <= operand_b;
              state  <= ST_ISSUE;
            end else begin
              res_data    <= '0;
              res_illegal <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_ISSUE: begin
          ula_op <= ULA_NOP;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          res_data    <= ula_result;
          res_illegal <= 1'b0;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequencer.sv
// tb_ula_sequencer -- directed self-checking bench for ula_sequencer.
// Includes a small registered ALU model that latches a result whenever
// ula_op is not NOP. Define ULA_SEQ_IMM_EN to exercise the I-type build.
module tb_ula_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [3:0]  ula_op;
  logic [31:0] ula_a;
  logic [31:0] ula_b;
  logic [31:0] ula_result;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_illegal;

  int checks = 0;
  int errors = 0;

  ula_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .ula_op      (ula_op),
    .ula_a       (ula_a),
    .ula_b       (ula_b),
    .ula_result  (ula_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_illegal (res_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model: registered output, holds on NOP.
  initial ula_result = 32'h0;
  always @(posedge clk) begin
    case (ula_op)
      4'b0000: ula_result <= ula_a & ula_b;
      4'b0001: ula_result <= ula_a | ula_b;
      4'b0010: ula_result <= ula_a + ula_b;
      4'b0110: ula_result <= ula_a - ula_b;
      4'b0111: ula_result <= ($signed(ula_a) < $signed(ula_b)) ? 32'd1 : 32'd0;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready"}, {31'b0, instr_ready}, 32'd1);
  endtask

  // Present one instruction and follow it to DONE (result not yet consumed).
  task automatic run_op(input string tag, input logic [31:0] word,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic legal, input logic [3:0] exp_op,
                        input logic [31:0] exp_b, input logic [31:0] exp_data);
    wait_ready(tag);
    instr = word; rs_data = a; rt_data = b; instr_valid = 1'b1;
    @(posedge clk); #1;                       // edge T0
    instr_valid = 1'b0;
    if (legal) begin
      check({tag, "_op_issue"}, {28'b0, ula_op}, {28'b0, exp_op});
      check({tag, "_a"}, ula_a, a);
      check({tag, "_b"}, ula_b, exp_b);
      check({tag, "_valid_t0"}, {31'b0, res_valid}, 32'd0);
      @(posedge clk); #1;                     // edge T1
      check({tag, "_op_wait"}, {28'b0, ula_op}, 32'hF);
      check({tag, "_valid_t1"}, {31'b0, res_valid}, 32'd0);
      @(posedge clk); #1;                     // edge T2
      check({tag, "_valid_t2"}, {31'b0, res_valid}, 32'd1);
      check({tag, "_illegal"}, {31'b0, res_illegal}, 32'd0);
      check({tag, "_data"}, res_data, exp_data);
    end else begin
      check({tag, "_valid"}, {31'b0, res_valid}, 32'd1);
      check({tag, "_illegal"}, {31'b0, res_illegal}, 32'd1);
      check({tag, "_data"}, res_data, 32'd0);
      check({tag, "_op"}, {28'b0, ula_op}, 32'hF);
    end
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_consumed"}, {31'b0, res_valid}, 32'd0);
    check({tag, "_idle"}, {31'b0, instr_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, instr_ready}, 32'd0);
    check("rst_valid", {31'b0, res_valid}, 32'd0);
    check("rst_op", {28'b0, ula_op}, 32'hF);
    check("rst_data", res_data, 32'd0);
    check("rst_a", ula_a, 32'd0);
    check("rst_b", ula_b, 32'd0);
    @(negedge clk); rst = 1'b0;

    // R-type functions
    run_op("add", 32'h012A4020, 32'd5, 32'd7, 1'b1, 4'b0010, 32'd7, 32'd12);
    consume("add");
    run_op("slt_lt", 32'h012A402A, 32'd3, 32'd9, 1'b1, 4'b0111, 32'd9, 32'd1);
    consume("slt_lt");
    run_op("slt_ge", 32'h012A402A, 32'd9, 32'd3, 1'b1, 4'b0111, 32'd3, 32'd0);
    consume("slt_ge");
    run_op("slt_neg", 32'h0000002A, 32'hFFFF_FFFF, 32'd1, 1'b1, 4'b0111, 32'd1, 32'd1);
    consume("slt_neg");
    run_op("sub", 32'h012A4022, 32'd10, 32'd3, 1'b1, 4'b0110, 32'd3, 32'd7);
    consume("sub");
    run_op("and", 32'h00000024, 32'h0000_F0F0, 32'h0000_FF00, 1'b1, 4'b0000, 32'h0000_FF00, 32'h0000_F000);
    consume("and");
    run_op("or", 32'h00000025, 32'h0000_F0F0, 32'h0000_FF00, 1'b1, 4'b0001, 32'h0000_FF00, 32'h0000_FFF0);
    consume("or");

    // Illegal funct and illegal opcode
    run_op("bad_funct", 32'h00000007, 32'd1, 32'd2, 1'b0, 4'hF, 32'd0, 32'd0);
    consume("bad_funct");
    run_op("lw", 32'h8C000004, 32'd1, 32'd2, 1'b0, 4'hF, 32'd0, 32'd0);
    consume("lw");

    // Backpressure: result held, new instruction ignored
    run_op("bp", 32'h00000020, 32'h11, 32'h22, 1'b1, 4'b0010, 32'h22, 32'h33);
    instr = 32'h00000022; rs_data = 32'h99; rt_data = 32'h1; instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'b0, res_valid}, 32'd1);
      check("bp_data", res_data, 32'h33);
      check("bp_ready", {31'b0, instr_ready}, 32'd0);
      check("bp_op", {28'b0, ula_op}, 32'hF);
    end
    instr_valid = 1'b0;
    consume("bp");
    check("bp_a_hold", ula_a, 32'h11);
    check("bp_b_hold", ula_b, 32'h22);

    // Reset during WAIT discards the in-flight result
    wait_ready("rst_wait");
    instr = 32'h00000020; rs_data = 32'd1; rt_data = 32'd2; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;                       // now in WAIT
    rst = 1'b1;
    #1;
    check("rw_valid", {31'b0, res_valid}, 32'd0);
    check("rw_op", {28'b0, ula_op}, 32'hF);
    check("rw_ready", {31'b0, instr_ready}, 32'd0);
    check("rw_a", ula_a, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rw_no_stale", {31'b0, res_valid}, 32'd0);
      check("rw_data", res_data, 32'd0);
    end
    check("rw_idle", {31'b0, instr_ready}, 32'd1);

`ifdef ULA_SEQ_IMM_EN
    run_op("addi", 32'h2021FFFF, 32'd1, 32'd0, 1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd0);
    consume("addi");
    run_op("andi", 32'h3000FFFF, 32'h1234_5678, 32'd0, 1'b1, 4'b0000, 32'h0000_FFFF, 32'h0000_5678);
    consume("andi");
    run_op("slti", 32'h2800FFFF, 32'd5, 32'd0, 1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd0);
    consume("slti");
    run_op("ori", 32'h34008001, 32'h0000_0F00, 32'd0, 1'b1, 4'b0001, 32'h0000_8001, 32'h0000_8F01);
    consume("ori");
`else
    run_op("addi_off", 32'h2021FFFF, 32'd1, 32'd0, 1'b0, 4'hF, 32'd0, 32'd0);
    consume("addi_off");
    run_op("ori_off", 32'h34008001, 32'd1, 32'd0, 1'b0, 4'hF, 32'd0, 32'd0);
    consume("ori_off");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ula_sequencer.md
ULA_SEQUENCER -- requirements
Module: ula_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 instr_valid  input  1  instruction and operands are valid.
REQ-005 instr_ready  output  1  sequencer can accept an instruction.
REQ-006 instr  input  32  MIPS instruction word (opcode bits 31:26, funct bits 5:0, immediate bits 15:0).
REQ-007 rs_data  input  32  first operand.
REQ-008 rt_data  input  32  second operand (R-type).
REQ-009 ula_op  output  4  operation code to the ALU.
REQ-010 ula_a  output  32  ALU operand a.
REQ-011 ula_b  output  32  ALU operand b.
REQ-012 ula_result  input  32  ALU registered result.
REQ-013 res_valid  output  1  result is available.
REQ-014 res_ready  input  1  consumer accepts the result.
REQ-015 res_data  output  32  captured result.
REQ-016 res_illegal  output  1  instruction was not decodable; qualified by res_valid.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT and DONE.
REQ-018 instr_ready SHALL be 1 only in IDLE with rst low.
REQ-019 In IDLE, on instr_valid=1: legal instruction -> ISSUE, with ula_op, ula_a=rs_data, ula_b registered on that edge; illegal -> DONE with res_illegal=1 and res_data=0, with no ALU operation issued.
REQ-020 R-type decode (opcode 000000), funct -> ula_op: 100000 add->0010, 100010 sub->0110, 100100 and->0000, 100101 or->0001, 101010 slt->0111; any other funct is illegal.
REQ-021 R-type: ula_b SHALL be rt_data.
REQ-022 Any non-R opcode SHALL be illegal unless enabled by REQ-032.
REQ-023 ISSUE SHALL last exactly one cycle, then go to WAIT; the ALU captures the operation on the edge that ends ISSUE.
REQ-024 ula_op SHALL be 1111 (no-op; the ALU holds its output) in every state except ISSUE.
REQ-025 WAIT SHALL last one cycle; on its ending edge, res_data <= ula_result, res_illegal <= 0, -> DONE.
REQ-026 In DONE, res_valid=1, and res_data/res_illegal SHALL remain stable until res_valid and res_ready are both 1 on the same edge; that edge -> IDLE.
REQ-027 Latency: accept edge T0 -> res_valid high after edge T2; minimum issue interval 4 cycles.
REQ-028 res_ready while not in DONE SHALL be ignored; instr_valid outside IDLE SHALL be ignored.
REQ-029 ula_a/ula_b SHALL hold their last issued values outside ISSUE.

Reset
REQ-030 rst SHALL force IDLE immediately, regardless of the current state (including ISSUE, WAIT or DONE), and set res_valid=0, res_illegal=0, res_data=0, ula_a=0, ula_b=0, ula_op=1111; any in-flight result SHALL be discarded.
REQ-031 The first accept SHALL occur no earlier than the first edge after rst deasserts.

Configuration
REQ-032 With ULA_SEQ_IMM_EN defined, the following I-types SHALL be legal, with ula_b = extended immediate: 001000 addi->0010 (sign-extended), 001010 slti->0111 (sign-extended), 001100 andi->0000 (zero-extended), 001101 ori->0001 (zero-extended).
REQ-033 Without ULA_SEQ_IMM_EN, those opcodes SHALL be illegal, and no immediate-extension logic SHALL be present.

Structure
REQ-034 Shared package ula_pkg SHALL hold: the ula_op codes, including NOP=1111; the opcode and funct constants; and the state enum.
REQ-035 Decode SHALL live in a combinational sub-module ula_decode (instr -> ula_op, legal, use_imm, sign_ext), instantiated once.

Verification
REQ-036 Scenario: add, rs=5, rt=7 -> ula_op=0010 for one cycle, res_data=12, res_valid after edge T2, res_illegal=0.
REQ-037 Scenario: slt, rs=3, rt=9, then slt, rs=9, rt=3 -> res_data=1, then 0; sub, 10-3 -> 7.
REQ-038 Scenario: funct 000111 -> res_valid after one edge, res_illegal=1, res_data=0, ula_op stays 1111 throughout.
REQ-039 Scenario: res_ready held 0 for 5 cycles in DONE -> res_data stable, instr_ready=0, new instr_valid ignored; res_ready=1 -> IDLE next edge.
REQ-040 Scenario: rst pulsed during WAIT -> IDLE, res_valid=0, ula_op=1111 immediately; no stale result later.
REQ-041 Scenario (ULA_SEQ_IMM_EN): addi, rs=1, imm=FFFF -> ula_b=FFFFFFFF, res_data=0; andi, imm=FFFF -> ula_b=0000FFFF; without the macro, addi -> res_illegal=1.
